// File: rtl/sram_xfer_pkg.sv
// Shared types and defaults for the backup-RAM transfer controller.
package sram_xfer_pkg;

  localparam int WORDS_DEFAULT = 16384;
  localparam int IDX_W         = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SAVE_ADDR,
    ST_SAVE_DATA,
    ST_SAVE_HOLD,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/sram_xfer_ctrl_if.sv
// Host word stream and backup-RAM port B signals of the transfer controller.
interface sram_xfer_ctrl_if;

  logic [31:0] host_wdata;
  logic        host_wvalid;
  logic        host_wready;
  logic [31:0] host_rdata;
  logic        host_rvalid;
  logic        host_rready;
  logic [15:0] sram_addr;
  logic        sram_wr;
  logic [31:0] sd_buff_dout;
  logic [31:0] sd_buff_din_sram;

  // controller side
  modport slave (
    input  host_wdata, host_wvalid, host_rready, sd_buff_din_sram,
    output host_wready, host_rdata, host_rvalid, sram_addr, sram_wr, sd_buff_dout
  );

  // host / RAM side
  modport master (
    output host_wdata, host_wvalid, host_rready, sd_buff_din_sram,
    input  host_wready, host_rdata, host_rvalid, sram_addr, sram_wr, sd_buff_dout
  );

endinterface

// File: rtl/sram_xfer_ctrl.sv
// Backup-RAM load/save controller: streams WORDS 32-bit words between the
// host and RAM port B and tracks whether the 68k modified the RAM.
//
// state        | meaning
// ST_IDLE      | waiting for load_req / save_req
// ST_LOAD      | accept host words, write each to RAM at idx
// ST_SAVE_ADDR | present idx to RAM
// ST_SAVE_DATA | RAM data valid, capture into host_rdata
// ST_SAVE_HOLD | host_rvalid held until host_rready
// ST_FINISH    | one-cycle done pulse, settle dirty
module sram_xfer_ctrl
  import sram_xfer_pkg::*;
#(
  parameter int WORDS = WORDS_DEFAULT
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             load_req,
  input  logic             save_req,
  input  logic             abort,
  input  logic             m68k_wr,
  output logic             busy,
  output logic             done,
  output logic             dirty,
  sram_xfer_ctrl_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             wready_q;
  logic             rvalid_q;
  logic [31:0]      rdata_q;
  logic             m68k_seen;
  logic             wr_accept;

  // An abort cycle must not write, so the accept is masked by abort.
  assign wr_accept        = (state == ST_LOAD) && wready_q && bus.host_wvalid && !abort;
  assign bus.host_wready  = wready_q && !abort;
  assign bus.sram_wr      = wr_accept;
  assign bus.sd_buff_dout = bus.host_wdata;
  assign bus.sram_addr    = {idx, 2'b00};
  assign bus.host_rdata   = rdata_q;
  assign bus.host_rvalid  = rvalid_q;

  // Transfer FSM with index counter, registered handshake outputs and dirty tracking.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dirty     <= 1'b0;
      wready_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      m68k_seen <= 1'b0;
    end else begin
      done <= 1'b0;
      if (m68k_wr) dirty <= 1'b1;
      if (state != ST_IDLE && m68k_wr) m68k_seen <= 1'b1;

      if (state != ST_IDLE && abort) begin
        state    <= ST_IDLE;
        busy     <= 1'b0;
        wready_q <= 1'b0;
        rvalid_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            // the start cycle itself counts as part of the operation
            m68k_seen <= m68k_wr;
            if (load_req) begin
              state    <= ST_LOAD;
              idx      <= '0;
              busy     <= 1'b1;
              wready_q <= 1'b1;
            end else if (save_req) begin
              state <= ST_SAVE_ADDR;
              idx   <= '0;
              busy  <= 1'b1;
            end
          end
          ST_LOAD: begin
            if (wr_accept) begin
              if (idx == LAST_IDX) begin
                state    <= ST_FINISH;
                wready_q <= 1'b0;
                done     <= 1'b1;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end
          end
          ST_SAVE_ADDR: state <= ST_SAVE_DATA;
          ST_SAVE_DATA: begin
            rdata_q  <= bus.sd_buff_din_sram;
            rvalid_q <= 1'b1;
            state    <= ST_SAVE_HOLD;
          end
          ST_SAVE_HOLD: begin
            if (bus.host_rready) begin
              rvalid_q <= 1'b0;
              if (idx == LAST_IDX) begin
                state <= ST_FINISH;
                done  <= 1'b1;
              end else begin
                idx   <= idx + IDX_W'(1);
                state <= ST_SAVE_ADDR;
              end
            end
          end
          ST_FINISH: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            dirty <= m68k_seen || m68k_wr;
          end
          default: begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            wready_q <= 1'b0;
            rvalid_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sram_xfer_ctrl.sv
// Directed bench for sram_xfer_ctrl with WORDS=4 and a small RAM model.
module tb_sram_xfer_ctrl;

  logic clk_sys, reset, load_req, save_req, abort, m68k_wr;
  logic busy, done, dirty;
  int   tests_run = 0;
  int   tests_failed = 0;

  sram_xfer_ctrl_if bus ();

  sram_xfer_ctrl #(.WORDS(4)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .load_req (load_req),
    .save_req (save_req),
    .abort    (abort),
    .m68k_wr  (m68k_wr),
    .busy     (busy),
    .done     (done),
    .dirty    (dirty),
    .bus      (bus)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // RAM port B model: synchronous write, read data one cycle after address
  logic [31:0] mem [0:15];
  always @(posedge clk_sys) begin
    if (bus.sram_wr) mem[bus.sram_addr[5:2]] <= bus.sd_buff_dout;
    bus.sd_buff_din_sram <= mem[bus.sram_addr[5:2]];
  end

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  // save with host_rready held high; returns cycle of done, -1 if none
  task automatic run_save_hold(input int m68k_cyc, output int cyc_done);
    bus.host_rready = 1'b1;
    save_req = 1'b1;
    tick;
    save_req = 1'b0;
    cyc_done = -1;
    for (int c = 1; c < 40; c++) begin
      m68k_wr = (c == m68k_cyc);
      #1;
      if (done) begin
        cyc_done = c;
        break;
      end
      tick;
    end
    m68k_wr = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    tests_run++;
    if ({busy, done, dirty, bus.host_wready, bus.host_rvalid, bus.sram_wr} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b want 000000",
               {busy, done, dirty, bus.host_wready, bus.host_rvalid, bus.sram_wr});
    end
    tests_run++;
    if (bus.host_rdata !== 32'h0 || bus.sram_addr !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_data: rdata %h addr %h want 0 0", bus.host_rdata, bus.sram_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_load;
    m68k_wr = 1'b1;
    tick;
    m68k_wr = 1'b0;
    #1;
    tests_run++;
    if (dirty !== 1'b1) begin
      tests_failed++;
      $display("FAIL dirty_set: got %b want 1", dirty);
    end
    load_req = 1'b1;
    tick;
    load_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.host_wvalid = 1'b1;
      bus.host_wdata  = 32'h11111111 * 32'(i + 1);
      #1;
      tests_run++;
      if ({busy, bus.host_wready, bus.sram_wr} !== 3'b111 || bus.sram_addr !== 16'(i * 4)) begin
        tests_failed++;
        $display("FAIL load_word%0d: busy/wready/wr %b addr %h want 111 %h", i,
                 {busy, bus.host_wready, bus.sram_wr}, bus.sram_addr, 16'(i * 4));
      end
      tick;
    end
    bus.host_wvalid = 1'b0;
    #1;
    tests_run++;
    if ({done, busy, bus.host_wready, bus.sram_wr} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL load_done: done/busy/wready/wr %b want 1100",
               {done, busy, bus.host_wready, bus.sram_wr});
    end
    tick;
    tests_run++;
    if ({done, busy, dirty} !== 3'b000) begin
      tests_failed++;
      $display("FAIL load_after: done/busy/dirty %b want 000", {done, busy, dirty});
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (mem[i] !== 32'h11111111 * 32'(i + 1)) begin
        tests_failed++;
        $display("FAIL load_mem%0d: got %h want %h", i, mem[i], 32'h11111111 * 32'(i + 1));
      end
    end
  endtask

  task automatic test_save_toggle;
    int k, dcnt;
    k = 0;
    dcnt = 0;
    bus.host_rready = 1'b0;
    save_req = 1'b1;
    tick;
    save_req = 1'b0;
    for (int c = 0; c < 80; c++) begin
      bus.host_rready = ~bus.host_rready;
      #1;
      if (bus.host_rvalid) begin
        tests_run++;
        if (bus.host_rdata !== 32'h11111111 * 32'(k + 1)) begin
          tests_failed++;
          $display("FAIL save_word%0d: got %h want %h", k, bus.host_rdata,
                   32'h11111111 * 32'(k + 1));
        end
        if (bus.host_rready) k++;
      end
      if (done) begin
        dcnt++;
        break;
      end
      tick;
    end
    bus.host_rready = 1'b0;
    tests_run++;
    if (k !== 4 || dcnt !== 1) begin
      tests_failed++;
      $display("FAIL save_count: words %0d done %0d want 4 1", k, dcnt);
    end
    tick;
    tests_run++;
    if ({done, busy, dirty, bus.host_rvalid} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL save_after: done/busy/dirty/rvalid %b want 0000",
               {done, busy, dirty, bus.host_rvalid});
    end
  endtask

  task automatic test_save_m68k;
    int c;
    run_save_hold(5, c);
    tests_run++;
    if (c !== 13) begin
      tests_failed++;
      $display("FAIL save_m68k_latency: done at cycle %0d want 13", c);
    end
    tick;
    tests_run++;
    if ({dirty, busy, done} !== 3'b100) begin
      tests_failed++;
      $display("FAIL save_m68k_dirty: dirty/busy/done %b want 100", {dirty, busy, done});
    end
  endtask

  task automatic test_save_clean;
    int c;
    run_save_hold(-1, c);
    tests_run++;
    if (c !== 13) begin
      tests_failed++;
      $display("FAIL save_clean_latency: done at cycle %0d want 13", c);
    end
    tests_run++;
    if (dirty !== 1'b1) begin
      tests_failed++;
      $display("FAIL save_clean_pre: dirty %b want 1 during FINISH", dirty);
    end
    tick;
    tests_run++;
    if (dirty !== 1'b0) begin
      tests_failed++;
      $display("FAIL save_clean_dirty: got %b want 0", dirty);
    end
  endtask

  task automatic test_both_req;
    load_req = 1'b1;
    save_req = 1'b1;
    tick;
    load_req = 1'b0;
    save_req = 1'b0;
    #1;
    tests_run++;
    if ({busy, bus.host_wready, bus.host_rvalid} !== 3'b110) begin
      tests_failed++;
      $display("FAIL both_req: busy/wready/rvalid %b want 110",
               {busy, bus.host_wready, bus.host_rvalid});
    end
    save_req = 1'b1;
    tick;
    save_req = 1'b0;
    tick;
    tests_run++;
    if ({bus.host_wready, bus.host_rvalid} !== 2'b10 || bus.sram_addr !== 16'h0) begin
      tests_failed++;
      $display("FAIL save_in_load: wready/rvalid %b addr %h want 10 0000",
               {bus.host_wready, bus.host_rvalid}, bus.sram_addr);
    end
    for (int i = 0; i < 4; i++) begin
      bus.host_wvalid = 1'b1;
      bus.host_wdata  = 32'h11111111 * 32'(i + 5);
      tick;
    end
    bus.host_wvalid = 1'b0;
    #1;
    tests_run++;
    if (done !== 1'b1 || mem[2] !== 32'h77777777) begin
      tests_failed++;
      $display("FAIL both_req_done: done %b mem2 %h want 1 77777777", done, mem[2]);
    end
    tick;
  endtask

  task automatic test_abort;
    m68k_wr = 1'b1;
    tick;
    m68k_wr = 1'b0;
    load_req = 1'b1;
    tick;
    load_req = 1'b0;
    bus.host_wvalid = 1'b1;
    bus.host_wdata  = 32'hA1A1A1A1;
    tick;
    bus.host_wdata  = 32'hA2A2A2A2;
    tick;
    bus.host_wdata  = 32'hDEADBEEF;
    abort = 1'b1;
    #1;
    tests_run++;
    if (bus.sram_wr !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_wr: got %b want 0", bus.sram_wr);
    end
    tick;
    abort = 1'b0;
    bus.host_wvalid = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, bus.host_wready, dirty} !== 4'b0001) begin
      tests_failed++;
      $display("FAIL abort_state: busy/done/wready/dirty %b want 0001",
               {busy, done, bus.host_wready, dirty});
    end
    tick;
    tests_run++;
    if (done !== 1'b0 || mem[0] !== 32'hA1A1A1A1 || mem[1] !== 32'hA2A2A2A2 ||
        mem[2] !== 32'h77777777) begin
      tests_failed++;
      $display("FAIL abort_mem: done %b mem %h %h %h want 0 a1a1a1a1 a2a2a2a2 77777777",
               done, mem[0], mem[1], mem[2]);
    end
  endtask

  task automatic test_reset_mid_save;
    logic got;
    bus.host_rready = 1'b0;
    save_req = 1'b1;
    tick;
    save_req = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      #1;
      if (bus.host_rvalid) got = 1'b1;
      else tick;
    end
    tests_run++;
    if (got !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_hold: rvalid never seen, got 0 want 1");
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tests_run++;
    if ({busy, done, dirty, bus.host_wready, bus.host_rvalid, bus.sram_wr} !== 6'b0 ||
        bus.host_rdata !== 32'h0 || bus.sram_addr !== 16'h0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: flags %b rdata %h addr %h want 000000 0 0",
               {busy, done, dirty, bus.host_wready, bus.host_rvalid, bus.sram_wr},
               bus.host_rdata, bus.sram_addr);
    end
    bus.host_rready = 1'b1;
    save_req = 1'b1;
    tick;
    save_req = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b1 || bus.sram_addr !== 16'h0) begin
      tests_failed++;
      $display("FAIL rst_mid_restart: busy %b addr %h want 1 0000", busy, bus.sram_addr);
    end
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      if (bus.host_rvalid) got = 1'b1;
      else tick;
    end
    tests_run++;
    if (got !== 1'b1 || bus.host_rdata !== 32'hA1A1A1A1) begin
      tests_failed++;
      $display("FAIL rst_mid_first: rvalid %b rdata %h want 1 a1a1a1a1", got, bus.host_rdata);
    end
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (done) got = 1'b1;
      else tick;
    end
    tests_run++;
    if (got !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_done: done seen %b want 1", got);
    end
    tick;
  endtask

  initial begin
    reset = 1'b1;
    load_req = 1'b0;
    save_req = 1'b0;
    abort = 1'b0;
    m68k_wr = 1'b0;
    bus.host_wdata = 32'h0;
    bus.host_wvalid = 1'b0;
    bus.host_rready = 1'b0;
    test_reset;
    test_load;
    test_save_toggle;
    test_save_m68k;
    test_save_clean;
    test_both_req;
    test_abort;
    test_reset_mid_save;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/sram_xfer_ctrl.md
SRAM_XFER_CTRL -- requirements
Module: sram_xfer_ctrl

Interface
REQ-001 Parameter WORDS, default 16384, SHALL set the number of 32-bit backup words transferred per operation (range 1..16384).
REQ-002 clk_sys  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 load_req  in  1  one-cycle pulse; start host->RAM load.
REQ-005 save_req  in  1  one-cycle pulse; start RAM->host save.
REQ-006 abort  in  1  cancel the current operation.
REQ-007 host_wdata  in  32  load word from host.
REQ-008 host_wvalid  in  1  host_wdata is valid.
REQ-009 host_wready  out  1  controller accepts host_wdata this cycle.
REQ-010 host_rdata  out  32  save word to host.
REQ-011 host_rvalid  out  1  host_rdata is valid.
REQ-012 host_rready  in  1  host accepts host_rdata this cycle.
REQ-013 sram_addr  out  16  byte address to the backup RAM port B; bits [1:0] always 0.
REQ-014 sram_wr  out  1  write strobe to the backup RAM port B.
REQ-015 sd_buff_dout  out  32  write data to the backup RAM.
REQ-016 sd_buff_din_sram  in  32  RAM read data, valid one cycle after sram_addr.
REQ-017 m68k_wr  in  1  one-cycle strobe, already synchronised to clk_sys, for any 68k backup-RAM write.
REQ-018 busy  out  1  operation in progress.
REQ-019 done  out  1  one-cycle pulse on normal completion.
REQ-020 dirty  out  1  RAM modified since the last completed load/save.

Function
REQ-021 States SHALL be IDLE, LOAD, SAVE_ADDR, SAVE_DATA, SAVE_HOLD, FINISH.
REQ-022 In IDLE, load_req SHALL go to LOAD and save_req SHALL go to SAVE_ADDR; both asserted together: load wins; word index idx cleared to 0.
REQ-023 load_req/save_req outside IDLE SHALL be ignored.
REQ-024 sram_addr SHALL equal {idx[13:0],2'b00} in all states.
REQ-025 LOAD: host_wready=1; on host_wvalid&host_wready, sram_wr=1 combinationally, sd_buff_dout=host_wdata, idx increments next cycle.
REQ-026 LOAD: the accepted word with idx==WORDS-1 SHALL cause a transition to FINISH; no further host_wready.
REQ-027 SAVE_ADDR: present idx for one cycle -> SAVE_DATA.
REQ-028 SAVE_DATA: capture sd_buff_din_sram into host_rdata, assert host_rvalid -> SAVE_HOLD.
REQ-029 SAVE_HOLD: host_rdata/host_rvalid stable until host_rready; on handshake, host_rvalid drops next cycle; idx==WORDS-1 -> FINISH, else idx+1 -> SAVE_ADDR.
REQ-030 sram_wr SHALL never assert outside LOAD.
REQ-031 FINISH: done=1 for exactly one cycle, busy=0 next cycle, return to IDLE.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 abort in any non-IDLE state SHALL return to IDLE next cycle, drop host_rvalid/host_wready, no done, dirty unchanged; abort in IDLE has no effect.
REQ-034 m68k_wr SHALL set dirty next cycle.
REQ-035 Completion of a save or load SHALL clear dirty, unless m68k_wr occurred at any cycle from operation start through the FINISH cycle, in which case dirty SHALL remain 1.
REQ-036 Save throughput with host_rready held high: one word per 3 cycles; load: one word per cycle.

Reset
REQ-037 reset SHALL force IDLE, idx=0, busy=0, done=0, dirty=0, host_wready=0, host_rvalid=0, sram_wr=0, host_rdata=0, in the next cycle, including mid-operation.

Structure
REQ-038 State encoding and the WORDS default SHALL live in shared package sram_xfer_pkg.
REQ-039 No sub-modules; single FSM plus index counter and dirty logic.

Verification
REQ-040 Load WORDS=4: save_req low, load_req pulse, host words 0x11111111..0x44444444 with wvalid high -> sram_wr at addresses 0x0000,0x0004,0x0008,0x000C consecutively, done one cycle after last.
REQ-041 Save WORDS=4 from preloaded RAM, host_rready toggling 1/0 -> host_rdata sequence exact, each word stable while rvalid&~rready, done once.
REQ-042 load_req and save_req same cycle -> LOAD entered; save_req during LOAD ignored.
REQ-043 abort after 2 of 4 load words -> IDLE next cycle, no done, 3rd word not written, busy=0.
REQ-044 m68k_wr during a save -> dirty=1 after done; save without m68k_wr -> dirty=0 after done.
REQ-045 reset asserted in SAVE_HOLD -> all outputs at reset values next cycle; subsequent save starts at sram_addr 0x0000.
